qos_flow_ctrl_fsm: RTL and testbench
====================================

Name: qos_flow_ctrl_fsm

Overview:
- Parametrised flow-control and status state machine for the PCIe QoS interconnect (main FIFO, VC FIFOs, D0/D1 output FIFOs).
- Generalises the fixed 5-FIFO controller to NFIFO channels with per-channel runtime thresholds.
- Adds per-channel hysteretic pause generation, sticky per-channel error capture, and threshold-consistency checking.
- Sits beside the FIFO bank; its pause outputs gate upstream pops/pushes, and its status outputs go to the top level.

Parameters:
NFIFO, 5, number of monitored FIFOs (index 0 = Main, then VCs, then Ds).
CW, 4, FIFO occupancy/threshold width in bits (supports depth up to 2^CW-1).

Ports:
clk  input  1  system clock, all flops rising-edge.
reset_L  input  1  asynchronous active-low reset.
init  input  1  configuration request; while high, thresholds are (re)loaded.
umbral_high_in  input  NFIFO*CW  per-channel almost-full thresholds, channel i at bits [i*CW +: CW].
umbral_low_in  input  NFIFO*CW  per-channel almost-empty thresholds, same packing.
fifo_count  input  NFIFO*CW  per-channel occupancy, same packing.
fifo_empty  input  NFIFO  per-channel empty flag.
fifo_error  input  NFIFO  per-channel overflow/underflow error pulse.
state  output  3  current state encoding.
idle_out  output  1  high in IDLE.
active_out  output  1  high in ACTIVE.
error_out  output  1  high in ERROR.
cfg_err  output  1  high if ERROR was entered due to an invalid threshold.
pause  output  NFIFO  per-channel back-pressure request.
error_full  output  NFIFO  sticky per-channel error record.

Behaviour:
- State encoding: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4. Values 5–7 are illegal and go to RESET on the next clock.
- Reset (async, any time, including mid-operation):
  - state=RESET; pause=0, error_full=0, cfg_err=0.
  - Threshold registers high_q=all ones, low_q=0.
  - idle_out=active_out=error_out=0.
- Status outputs are Moore outputs decoded directly from the state register. They change in the same cycle as the state.
- RESET -> INIT unconditionally on the first clock after reset deasserts.
- INIT:
  - high_q/low_q load from the inputs on every clock while init=1 or while in INIT.
  - pause is held at 0.
  - Leaves INIT on the first clock with init=0.
  - If any channel has low_q >= high_q (using the values loaded that cycle), next state is ERROR and cfg_err is set to 1. Otherwise next state is IDLE.
- Transition priority in IDLE/ACTIVE, highest first:
  1. Any fifo_error bit or any error_full bit -> ERROR.
  2. init=1 -> INIT.
  3. IDLE: any fifo_empty=0 -> ACTIVE.
  4. ACTIVE: all fifo_empty=1 -> IDLE.
  5. Otherwise stay.
- ERROR is absorbing. Only reset_L exits it; init is ignored. pause is forced to all ones in ERROR.
- error_full[i]: set one clock after fifo_error[i]=1, in any state except RESET. Cleared only by reset. Simultaneous errors on several channels all set their bits in the same cycle.
- pause[i] is registered with one-cycle latency, in IDLE/ACTIVE only:
  - Set when count_i >= high_q_i.
  - Cleared when count_i <= low_q_i.
  - Otherwise holds.
  - If both conditions are true (possible only transiently), set wins.
- Comparisons are unsigned, CW bits wide; no wrap or extension is required.
- Leaving ACTIVE/IDLE for INIT clears pause on entry.

Test Plan:
- Reset then init=1 for 1 cycle with high=3, low=1 on all channels, fifo_empty=all ones -> state 0,1,2 on successive clocks; idle_out=1; pause=0.
- From IDLE, fifo_empty[2]=0, count_2 = 1,2,3,2,1 on successive clocks -> ACTIVE next clock; pause[2] rises the clock after count=3, stays high at count=2, falls the clock after count=1.
- In ACTIVE, pulse fifo_error[4] and fifo_error[0] in the same cycle -> next clock state=4, error_out=1, error_full=5'b10001, pause=all ones. Then init=1 and data changes -> remain ERROR.
- Init with channel 3 high=2, low=2, then init=0 -> state goes 1 -> 4 with cfg_err=1, error_full=0.
- Assert reset_L=0 asynchronously mid-cycle while in ACTIVE with pause[1]=1 -> all outputs 0 and state=0 immediately, without waiting for a clock edge.
- In ACTIVE, raise init with fifo_error=0 -> INIT next clock with pause=0. Load new thresholds high=15, low=0, drop init -> IDLE or ACTIVE per the fifo_empty inputs.

Source files
------------

// File: rtl/qos_flow_ctrl_fsm.sv
// Flow-control/status FSM for the QoS FIFO bank: per-channel runtime thresholds,
// hysteretic pause generation, sticky error capture and threshold sanity checking.
module qos_flow_ctrl_fsm #(
  parameter int NFIFO = 5,
  parameter int CW    = 4
) (
  input  logic                clk,
  input  logic                reset_L,
  input  logic                init,
  input  logic [NFIFO*CW-1:0] umbral_high_in,
  input  logic [NFIFO*CW-1:0] umbral_low_in,
  input  logic [NFIFO*CW-1:0] fifo_count,
  input  logic [NFIFO-1:0]    fifo_empty,
  input  logic [NFIFO-1:0]    fifo_error,
  output logic [2:0]          state,
  output logic                idle_out,
  output logic                active_out,
  output logic                error_out,
  output logic                cfg_err,
  output logic [NFIFO-1:0]    pause,
  output logic [NFIFO-1:0]    error_full
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [NFIFO*CW-1:0] high_q, high_d;
  logic [NFIFO*CW-1:0] low_q, low_d;
  logic [NFIFO-1:0]    pause_q, pause_d;
  logic [NFIFO-1:0]    error_full_q, error_full_d;
  logic                cfg_err_q, cfg_err_d;
  logic                load_en;
  logic                cfg_bad;
  logic                run_q, run_d;

  always_comb begin
    state_d      = state_q;
    high_d       = high_q;
    low_d        = low_q;
    pause_d      = pause_q;
    error_full_d = error_full_q;
    cfg_err_d    = cfg_err_q;
    cfg_bad      = 1'b0;
    run_q        = 1'b0;
    run_d        = 1'b0;

    // Thresholds track the inputs for the whole INIT stay; ERROR ignores init.
    load_en = (state_q == ST_INIT) || (init && (state_q != ST_ERROR));
    if (load_en) begin
      high_d = umbral_high_in;
      low_d  = umbral_low_in;
    end

    // Validated against the inputs, i.e. the values being loaded on the exit clock.
    for (int i = 0; i < NFIFO; i++) begin
      if (umbral_low_in[i*CW +: CW] >= umbral_high_in[i*CW +: CW]) cfg_bad = 1'b1;
    end

    if (state_q != ST_RESET) error_full_d = error_full_q | fifo_error;

    case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT: begin
        if (!init) begin
          if (cfg_bad) begin
            state_d   = ST_ERROR;
            cfg_err_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_IDLE, ST_ACTIVE: begin
        if ((|fifo_error) || (|error_full_q))              state_d = ST_ERROR;
        else if (init)                                     state_d = ST_INIT;
        else if ((state_q == ST_IDLE) && !(&fifo_empty))   state_d = ST_ACTIVE;
        else if ((state_q == ST_ACTIVE) && (&fifo_empty))  state_d = ST_IDLE;
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_RESET;
    endcase

    run_q = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
    run_d = (state_d == ST_IDLE) || (state_d == ST_ACTIVE);

    // Pause follows the state being entered: forced high into ERROR, zero elsewhere
    // outside the running states, hysteresis only while staying in IDLE/ACTIVE.
    if (state_d == ST_ERROR) begin
      pause_d = '1;
    end else if (run_q && run_d) begin
      for (int i = 0; i < NFIFO; i++) begin
        if (fifo_count[i*CW +: CW] >= high_q[i*CW +: CW])     pause_d[i] = 1'b1;
        else if (fifo_count[i*CW +: CW] <= low_q[i*CW +: CW]) pause_d[i] = 1'b0;
      end
    end else begin
      pause_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q      <= ST_RESET;
      high_q       <= '1;
      low_q        <= '0;
      pause_q      <= '0;
      error_full_q <= '0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      high_q       <= high_d;
      low_q        <= low_d;
      pause_q      <= pause_d;
      error_full_q <= error_full_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign state      = state_q;
  assign idle_out   = (state_q == ST_IDLE);
  assign active_out = (state_q == ST_ACTIVE);
  assign error_out  = (state_q == ST_ERROR);
  assign cfg_err    = cfg_err_q;
  assign pause      = pause_q;
  assign error_full = error_full_q;

endmodule

// File: tb/tb_qos_flow_ctrl_fsm.sv
// Bench for qos_flow_ctrl_fsm: vector table for the main flow, hand sequences for
// config error, asynchronous reset and re-initialisation from ACTIVE.
module tb_qos_flow_ctrl_fsm;

  localparam int NFIFO = 5;
  localparam int CW    = 4;
  localparam int W     = 17;

  logic                clk;
  logic                reset_L;
  logic                init;
  logic [NFIFO*CW-1:0] umbral_high_in;
  logic [NFIFO*CW-1:0] umbral_low_in;
  logic [NFIFO*CW-1:0] fifo_count;
  logic [NFIFO-1:0]    fifo_empty;
  logic [NFIFO-1:0]    fifo_error;
  logic [2:0]          state;
  logic                idle_out;
  logic                active_out;
  logic                error_out;
  logic                cfg_err;
  logic [NFIFO-1:0]    pause;
  logic [NFIFO-1:0]    error_full;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  qos_flow_ctrl_fsm #(.NFIFO(NFIFO), .CW(CW)) dut (
    .clk            (clk),
    .reset_L        (reset_L),
    .init           (init),
    .umbral_high_in (umbral_high_in),
    .umbral_low_in  (umbral_low_in),
    .fifo_count     (fifo_count),
    .fifo_empty     (fifo_empty),
    .fifo_error     (fifo_error),
    .state          (state),
    .idle_out       (idle_out),
    .active_out     (active_out),
    .error_out      (error_out),
    .cfg_err        (cfg_err),
    .pause          (pause),
    .error_full     (error_full)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string      name;
    logic       init;
    logic [19:0] hi;
    logic [19:0] lo;
    logic [19:0] cnt;
    logic [4:0] empty;
    logic [4:0] err;
    logic [2:0] st;
    logic       cfg;
    logic [4:0] p;
    logic [4:0] ef;
  } vec_t;

  vec_t vecs[11];

  // Expected word: {state, idle, active, error, cfg_err, pause, error_full}
  function automatic logic [W-1:0] pack_exp(input logic [2:0] st, input logic cfg,
                                            input logic [4:0] p, input logic [4:0] ef);
    return {st, (st == 3'd2), (st == 3'd3), (st == 3'd4), cfg, p, ef};
  endfunction

  function automatic logic [W-1:0] actual_word();
    return {state, idle_out, active_out, error_out, cfg_err, pause, error_full};
  endfunction

  // Scoreboard compare against the oldest expected entry
  task automatic check_out(input string name);
    logic [W-1:0] exp_w;
    logic [W-1:0] act_w;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: actual=no_expected required=queued_entry", name);
    end else begin
      exp_w = exp_q.pop_front();
      act_w = actual_word();
      if (act_w !== exp_w) begin
        failures++;
        $display("FAIL %s: actual state=%0d idle/act/err=%b%b%b cfg=%b pause=%b ef=%b required state=%0d idle/act/err=%b%b%b cfg=%b pause=%b ef=%b",
                 name, act_w[16:14], act_w[13], act_w[12], act_w[11], act_w[10], act_w[9:5], act_w[4:0],
                 exp_w[16:14], exp_w[13], exp_w[12], exp_w[11], exp_w[10], exp_w[9:5], exp_w[4:0]);
      end
    end
  endtask

  // Driver: apply inputs, queue expectation, clock once, compare after the edge
  task automatic step(input string name, input logic i_init, input logic [19:0] hi,
                      input logic [19:0] lo, input logic [19:0] cnt, input logic [4:0] emp,
                      input logic [4:0] err, input logic [2:0] st, input logic cfg,
                      input logic [4:0] p, input logic [4:0] ef);
    init           = i_init;
    umbral_high_in = hi;
    umbral_low_in  = lo;
    fifo_count     = cnt;
    fifo_empty     = emp;
    fifo_error     = err;
    exp_q.push_back(pack_exp(st, cfg, p, ef));
    @(posedge clk);
    #1;
    check_out(name);
  endtask

  task automatic do_reset(input string name);
    @(posedge clk);
    #2;
    reset_L = 1'b0;
    #1;
    exp_q.push_back(pack_exp(3'd0, 1'b0, 5'b0, 5'b0));
    check_out(name);
    @(negedge clk);
    reset_L = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Drives RESET -> INIT -> IDLE with uniform high=3/low=1 thresholds
  task automatic bring_up(input string tag);
    step({tag, "_init"}, 1'b1, 20'h33333, 20'h11111, 20'h0, 5'b11111, 5'b0, 3'd1, 1'b0, 5'b0, 5'b0);
    step({tag, "_idle"}, 1'b0, 20'h33333, 20'h11111, 20'h0, 5'b11111, 5'b0, 3'd2, 1'b0, 5'b0, 5'b0);
  endtask

  initial begin
    // Main flow: bring-up, hysteresis on channel 2, dual error, ERROR absorbing.
    vecs[0]  = '{"tp1_init",       1'b1, 20'h33333, 20'h11111, 20'h00000, 5'b11111, 5'b00000, 3'd1, 1'b0, 5'b00000, 5'b00000};
    vecs[1]  = '{"tp1_idle",       1'b0, 20'h33333, 20'h11111, 20'h00000, 5'b11111, 5'b00000, 3'd2, 1'b0, 5'b00000, 5'b00000};
    vecs[2]  = '{"idle_hold",      1'b0, 20'h33333, 20'h11111, 20'h00000, 5'b11111, 5'b00000, 3'd2, 1'b0, 5'b00000, 5'b00000};
    vecs[3]  = '{"active_c1",      1'b0, 20'h33333, 20'h11111, 20'h00100, 5'b11011, 5'b00000, 3'd3, 1'b0, 5'b00000, 5'b00000};
    vecs[4]  = '{"active_c2",      1'b0, 20'h33333, 20'h11111, 20'h00200, 5'b11011, 5'b00000, 3'd3, 1'b0, 5'b00000, 5'b00000};
    vecs[5]  = '{"pause_set_c3",   1'b0, 20'h33333, 20'h11111, 20'h00300, 5'b11011, 5'b00000, 3'd3, 1'b0, 5'b00100, 5'b00000};
    vecs[6]  = '{"pause_hold_c2",  1'b0, 20'h33333, 20'h11111, 20'h00200, 5'b11011, 5'b00000, 3'd3, 1'b0, 5'b00100, 5'b00000};
    vecs[7]  = '{"pause_clr_c1",   1'b0, 20'h33333, 20'h11111, 20'h00100, 5'b11011, 5'b00000, 3'd3, 1'b0, 5'b00000, 5'b00000};
    vecs[8]  = '{"dual_error",     1'b0, 20'h33333, 20'h11111, 20'h00100, 5'b11011, 5'b10001, 3'd4, 1'b0, 5'b11111, 5'b10001};
    vecs[9]  = '{"error_absorb",   1'b1, 20'h77777, 20'h00000, 20'h54321, 5'b00000, 5'b00000, 3'd4, 1'b0, 5'b11111, 5'b10001};
    vecs[10] = '{"error_sticky",   1'b0, 20'h77777, 20'h00000, 20'h00000, 5'b11111, 5'b00010, 3'd4, 1'b0, 5'b11111, 5'b10011};

    reset_L        = 1'b0;
    init           = 1'b0;
    umbral_high_in = 20'h33333;
    umbral_low_in  = 20'h11111;
    fifo_count     = '0;
    fifo_empty     = '1;
    fifo_error     = '0;

    #12;
    exp_q.push_back(pack_exp(3'd0, 1'b0, 5'b0, 5'b0));
    check_out("reset_state");
    @(negedge clk);
    reset_L = 1'b1;
    #1;
    exp_q.push_back(pack_exp(3'd0, 1'b0, 5'b0, 5'b0));
    check_out("reset_release");

    for (int i = 0; i < 11; i++) begin
      step(vecs[i].name, vecs[i].init, vecs[i].hi, vecs[i].lo, vecs[i].cnt, vecs[i].empty,
           vecs[i].err, vecs[i].st, vecs[i].cfg, vecs[i].p, vecs[i].ef);
    end

    // Invalid threshold on channel 3 (low == high)
    do_reset("reset_from_error");
    step("cfg_init",  1'b1, 20'h32333, 20'h12111, 20'h0, 5'b11111, 5'b0, 3'd1, 1'b0, 5'b00000, 5'b0);
    step("cfg_error", 1'b0, 20'h32333, 20'h12111, 20'h0, 5'b11111, 5'b0, 3'd4, 1'b1, 5'b11111, 5'b0);
    step("cfg_absorb",1'b1, 20'h33333, 20'h11111, 20'h0, 5'b11111, 5'b0, 3'd4, 1'b1, 5'b11111, 5'b0);

    // Asynchronous reset while ACTIVE with pause[1] high
    do_reset("reset_from_cfg");
    bring_up("c");
    step("c_active_p1", 1'b0, 20'h33333, 20'h11111, 20'h00030, 5'b11101, 5'b0, 3'd3, 1'b0, 5'b00010, 5'b0);
    step("c_hold_p1",   1'b0, 20'h33333, 20'h11111, 20'h00030, 5'b11101, 5'b0, 3'd3, 1'b0, 5'b00010, 5'b0);
    do_reset("async_reset_active");

    // Re-initialisation from ACTIVE, then new wide thresholds
    bring_up("d");
    step("d_active_p1", 1'b0, 20'h33333, 20'h11111, 20'h00030, 5'b11101, 5'b0, 3'd3, 1'b0, 5'b00010, 5'b0);
    step("d_reinit",    1'b1, 20'h33333, 20'h11111, 20'h00030, 5'b11101, 5'b0, 3'd1, 1'b0, 5'b00000, 5'b0);
    step("d_load_wide", 1'b1, 20'hFFFFF, 20'h00000, 20'h00030, 5'b11101, 5'b0, 3'd1, 1'b0, 5'b00000, 5'b0);
    step("d_exit_idle", 1'b0, 20'hFFFFF, 20'h00000, 20'h00030, 5'b11101, 5'b0, 3'd2, 1'b0, 5'b00000, 5'b0);
    step("d_active",    1'b0, 20'h33333, 20'h11111, 20'h00030, 5'b11101, 5'b0, 3'd3, 1'b0, 5'b00000, 5'b0);
    step("d_full_15",   1'b0, 20'h33333, 20'h11111, 20'h000F0, 5'b11101, 5'b0, 3'd3, 1'b0, 5'b00010, 5'b0);
    step("d_mid_7",     1'b0, 20'h33333, 20'h11111, 20'h00070, 5'b11101, 5'b0, 3'd3, 1'b0, 5'b00010, 5'b0);
    step("d_empty_0",   1'b0, 20'h33333, 20'h11111, 20'h00000, 5'b11101, 5'b0, 3'd3, 1'b0, 5'b00000, 5'b0);
    step("d_to_idle",   1'b0, 20'h33333, 20'h11111, 20'h00000, 5'b11111, 5'b0, 3'd2, 1'b0, 5'b00000, 5'b0);
    step("d_err_prio",  1'b1, 20'h33333, 20'h11111, 20'h00000, 5'b00000, 5'b00100, 3'd4, 1'b0, 5'b11111, 5'b00100);

    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
